mem_stream_ctrl: RTL and testbench
==================================

Name: mem_stream_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous word memory (1-cycle registered read, read-before-write on the same address).
- Accepts an input stream frame via valid/ready and writes it into the memory from address 0, up to SIZE words.
- Then reads the frame back out in order as an output stream, honouring backpressure at full throughput.
- Sits between upstream producers and downstream consumers; the memory is instantiated alongside it, not inside it.

Parameters:
- WIDTH, 16, bits per word; must match the memory's WIDTH.
- SIZE, 64, memory depth in words; must match the memory's SIZE and be >= 2.
- LOGSIZE, $clog2(SIZE), localparam, address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  controller accepts an input word.
- s_data  input  WIDTH  input word.
- s_last  input  1  marks the final word of the input frame.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the output word.
- m_data  output  WIDTH  output word; driven directly from mem_rdata.
- m_last  output  1  marks the final word of the output frame.
- mem_addr  output  LOGSIZE  memory address.
- mem_wr_en  output  1  memory write enable.
- mem_wdata  output  WIDTH  memory write data; equals s_data.
- mem_rdata  input  WIDTH  memory registered read data.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- State machine: two states, LOAD and DRAIN.
- Registers: wr_ptr (LOGSIZE), rd_idx (LOGSIZE), last_idx (LOGSIZE), m_valid.
- Reset values: state=LOAD, wr_ptr=0, rd_idx=0, last_idx=0, m_valid=0.
- During a reset cycle: s_ready=0, mem_wr_en=0, m_last=0.
- LOAD state:
  - s_ready=1; mem_addr=wr_ptr; mem_wr_en = s_valid & s_ready.
  - On each accepted word, wr_ptr increments.
  - Frame ends on an accept with s_last=1, or on an accept with wr_ptr==SIZE-1 (memory full; s_last is not required).
  - At frame end: last_idx<=wr_ptr, wr_ptr<=0, rd_idx<=0, go to DRAIN.
  - m_valid=0 throughout LOAD.
- DRAIN state:
  - s_ready=0; mem_wr_en=0.
  - Read address (combinational): mem_addr = rd_idx+1 when (m_valid & m_ready), else rd_idx.
  - First cycle in DRAIN: m_valid=0 (read of address 0 in flight). m_valid<=1 at the end of that cycle.
  - Handshake = m_valid & m_ready. On a handshake that is not the last word: rd_idx increments. mem_rdata on the next cycle then holds the new word, so throughput is 1 word/cycle with no bubbles.
  - m_last = m_valid & (rd_idx==last_idx).
  - On the m_last handshake: m_valid<=0, rd_idx<=0, go to LOAD. s_ready=1 on the next cycle.
- Latency: first m_valid is asserted 2 cycles after the clock edge that writes the last input word.
- Stall: while m_valid & !m_ready, mem_addr is held, so m_data re-reads the same word and stays stable. No memory writes occur in DRAIN.
- Input handling: s_valid in DRAIN is ignored and not accepted. s_data/s_last are don't-care when s_valid=0.
- Wrap-around: pointers never exceed SIZE-1; a frame longer than SIZE is split, and the remaining words start a new frame after the drain.
- Reset mid-operation: either state aborts immediately to LOAD with reset values. The partial frame is discarded and no m_last is emitted. Memory contents are undefined and not relied on.
- Single-word frame: last_idx=0; m_valid and m_last are asserted together.

Test Plan:
- Frame 0x0011,0x0022,0x0033,0x0044 with s_last on the 4th word, m_ready=1 -> m_data is 0x0011..0x0044 on 4 consecutive cycles, m_last only with 0x0044, first m_valid 2 cycles after the 4th write. s_ready=1 again on the cycle after the 0x0044 handshake.
- 64 words 0..63 with s_last never asserted -> s_ready drops after word 63; output 0..63 with m_last on 63.
- Frame 0xA..0xF with m_ready toggling 1,0,0,1,0,1... -> m_data is held stable during stalls, there are no duplicates or drops, and order is preserved.
- Single word 0xBEEF with s_last -> one output beat, 0xBEEF with m_valid=m_last=1; then a second frame 0x1,0x2 is accepted and output correctly.
- Reset asserted after the 3rd output beat of an 8-word frame -> the next cycle has m_valid=0 and s_ready=1; a new 2-word frame 0x5,0x6 outputs only 0x5,0x6.
- s_valid held high during DRAIN with s_data=0xDEAD -> mem_wr_en stays 0 and the output frame is uncorrupted.

Source files
------------

// File: rtl/mem_stream_ctrl.sv
// Frame buffer controller: loads an input stream frame into an external
// single-port word memory from address 0, then streams it back out in order.
module mem_stream_ctrl #(
   parameter  int unsigned WIDTH   = 16,
   parameter  int unsigned SIZE    = 64,
   localparam int unsigned LOGSIZE = $clog2(SIZE)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WIDTH-1:0]   s_data,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [WIDTH-1:0]   m_data,
   output logic               m_last,
   output logic [LOGSIZE-1:0] mem_addr,
   output logic               mem_wr_en,
   output logic [WIDTH-1:0]   mem_wdata,
   input  logic [WIDTH-1:0]   mem_rdata
);

   localparam logic [LOGSIZE-1:0] MAX_IDX = LOGSIZE'(SIZE - 1);
   localparam logic [LOGSIZE-1:0] ONE     = LOGSIZE'(1);

   typedef enum logic {LOAD, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [LOGSIZE-1:0] wr_ptr, wr_ptr_nxt;
   logic [LOGSIZE-1:0] rd_idx, rd_idx_nxt;
   logic [LOGSIZE-1:0] last_idx, last_idx_nxt;
   logic               m_valid_nxt;
   logic               hs;

   // Write data and read data pass straight through to/from the memory.
   assign mem_wdata = s_data;
   assign m_data    = mem_rdata;

   // State and pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= LOAD;
         wr_ptr   <= '0;
         rd_idx   <= '0;
         last_idx <= '0;
         m_valid  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wr_ptr   <= wr_ptr_nxt;
         rd_idx   <= rd_idx_nxt;
         last_idx <= last_idx_nxt;
         m_valid  <= m_valid_nxt;
      end
   end

   // Next-state logic; the memory address looks one word ahead on a handshake
   // so the registered read keeps up with a 1 word/cycle drain.
   always_comb begin
      state_nxt    = state;
      wr_ptr_nxt   = wr_ptr;
      rd_idx_nxt   = rd_idx;
      last_idx_nxt = last_idx;
      m_valid_nxt  = m_valid;
      s_ready      = 1'b0;
      mem_wr_en    = 1'b0;
      m_last       = 1'b0;
      mem_addr     = rd_idx;
      hs           = 1'b0;
      case (state)
         LOAD: begin
            s_ready     = !reset;
            mem_addr    = wr_ptr;
            mem_wr_en   = s_valid & !reset;
            m_valid_nxt = 1'b0;
            if (s_valid) begin
               wr_ptr_nxt = wr_ptr + ONE;
               if (s_last || (wr_ptr == MAX_IDX)) begin
                  last_idx_nxt = wr_ptr;
                  wr_ptr_nxt   = '0;
                  rd_idx_nxt   = '0;
                  state_nxt    = DRAIN;
               end
            end
         end
         DRAIN: begin
            m_last      = m_valid & (rd_idx == last_idx) & !reset;
            hs          = m_valid & m_ready;
            mem_addr    = hs ? (rd_idx + ONE) : rd_idx;
            m_valid_nxt = 1'b1;
            if (hs) begin
               if (rd_idx == last_idx) begin
                  m_valid_nxt = 1'b0;
                  rd_idx_nxt  = '0;
                  state_nxt   = LOAD;
               end else begin
                  rd_idx_nxt = rd_idx + ONE;
               end
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Self-checking bench for mem_stream_ctrl with a behavioural single-port memory.
module tb_mem_stream_ctrl;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned SIZE    = 64;
   localparam int unsigned LOGSIZE = 6;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic [WIDTH-1:0]   s_data = '0;
   logic               s_last = 1'b0;
   logic               m_valid;
   logic               m_ready = 1'b0;
   logic [WIDTH-1:0]   m_data;
   logic               m_last;
   logic [LOGSIZE-1:0] mem_addr;
   logic               mem_wr_en;
   logic [WIDTH-1:0]   mem_wdata;
   logic [WIDTH-1:0]   mem_rdata;

   mem_stream_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port memory: registered read, read-before-write.
   logic [WIDTH-1:0] mem [SIZE];
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             s_last;
      logic             exp_m_last;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   frame_start[8];
   int   frame_len[8];

   int tests = 0;
   int fails = 0;
   int beats = 0;

   logic       mon_en = 1'b0;
   int         rdy_mode = 0;
   logic       rdy_low = 1'b1;
   logic [5:0] rdy_pat = 6'b101001;
   int         cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // m_ready driver: always ready, or the repeating 1,0,0,1,0,1 pattern.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rdy_low) m_ready = 1'b0;
      else if (rdy_mode == 0) m_ready = 1'b1;
      else m_ready = rdy_pat[cyc % 6];
   end

   // Output monitor: scoreboard pop on handshake, stall and post-frame checks.
   logic             stall_prev = 1'b0;
   logic             last_hs_prev = 1'b0;
   logic [WIDTH-1:0] data_prev = '0;
   always @(negedge clk) begin
      if (!mon_en) begin
         stall_prev   = 1'b0;
         last_hs_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid_held", 32'(m_valid), 32'd1);
            chk("stall_data_held", 32'(m_data), 32'(data_prev));
         end
         if (last_hs_prev) begin
            chk("ready_after_last", 32'(s_ready), 32'd1);
            chk("valid_low_after_last", 32'(m_valid), 32'd0);
         end
         if (m_valid) chk("no_write_in_drain", 32'(mem_wr_en), 32'd0);
         if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("m_data", 32'(m_data), 32'(e.data));
               chk("m_last", 32'(m_last), 32'(e.last));
            end
            beats++;
         end
         stall_prev   = m_valid && !m_ready;
         last_hs_prev = m_valid && m_ready && m_last;
         data_prev    = m_data;
      end
   end

   task automatic add(input logic [WIDTH-1:0] d, input logic sl, input logic el);
      vec_t v;
      v.data = d; v.s_last = sl; v.exp_m_last = el;
      vecs.push_back(v);
   endtask

   // Drive one frame word by word; push expectations as each word is accepted.
   task automatic send_frame(input int f);
      for (int i = frame_start[f]; i < frame_start[f] + frame_len[f]; i++) begin
         bit acc;
         exp_t e;
         acc = 1'b0;
         s_valid = 1'b1;
         s_data  = vecs[i].data;
         s_last  = vecs[i].s_last;
         for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            if (s_ready) begin
               acc = 1'b1;
               e.data = vecs[i].data;
               e.last = vecs[i].exp_m_last;
               sb.push_back(e);
            end
            @(posedge clk);
            #1;
         end
         chk("input_accepted", 32'(acc), 32'd1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // First m_valid arrives on the second cycle after the final write.
   task automatic check_latency();
      @(negedge clk);
      chk("lat_cycle1_valid", 32'(m_valid), 32'd0);
      chk("lat_cycle1_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 32'(m_valid), 32'd1);
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      s_valid = 1'b0;
      chk("drain_done", 32'(sb.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int b0;
      bit hit;
      // Vector table: frames and their expected output last flags.
      frame_start[0] = vecs.size(); frame_len[0] = 4;
      add(16'h0011, 0, 0); add(16'h0022, 0, 0); add(16'h0033, 0, 0); add(16'h0044, 1, 1);
      frame_start[1] = vecs.size(); frame_len[1] = 64;
      for (int i = 0; i < 64; i++) add(16'(i), 1'b0, (i == 63));
      frame_start[2] = vecs.size(); frame_len[2] = 6;
      for (int i = 10; i < 16; i++) add(16'(i), (i == 15), (i == 15));
      frame_start[3] = vecs.size(); frame_len[3] = 1;
      add(16'hBEEF, 1, 1);
      frame_start[4] = vecs.size(); frame_len[4] = 2;
      add(16'h0001, 0, 0); add(16'h0002, 1, 1);
      frame_start[5] = vecs.size(); frame_len[5] = 8;
      for (int i = 0; i < 8; i++) add(16'(16'h0100 + i), (i == 7), (i == 7));
      frame_start[6] = vecs.size(); frame_len[6] = 2;
      add(16'h0005, 0, 0); add(16'h0006, 1, 1);
      frame_start[7] = vecs.size(); frame_len[7] = 4;
      for (int i = 1; i < 5; i++) add(16'(16'h0C00 + i), (i == 4), (i == 4));

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      rdy_low = 1'b0;
      @(negedge clk);
      chk("idle_s_ready", 32'(s_ready), 32'd1);
      chk("idle_m_valid", 32'(m_valid), 32'd0);
      chk("idle_mem_addr", 32'(mem_addr), 32'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Frames 0..4: basic, full-memory, toggling backpressure, single word, follow-up.
      for (int f = 0; f < 5; f++) begin
         rdy_mode = (f == 2) ? 1 : 0;
         send_frame(f);
         check_latency();
         wait_drain();
      end
      rdy_mode = 0;

      // Reset after the third output beat of an 8-word frame.
      b0 = beats;
      send_frame(5);
      check_latency();
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(posedge clk); #1;
         if (beats >= b0 + 3) hit = 1'b1;
      end
      chk("three_beats_seen", 32'(hit), 32'd1);
      mon_en  = 1'b0;
      rdy_low = 1'b1;
      m_ready = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("midrst_m_last", 32'(m_last), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("postrst_m_valid", 32'(m_valid), 32'd0);
      chk("postrst_s_ready", 32'(s_ready), 32'd1);
      mon_en  = 1'b1;
      rdy_low = 1'b0;
      @(posedge clk); #1;
      send_frame(6);
      check_latency();
      wait_drain();

      // Input held valid with junk data while draining.
      send_frame(7);
      s_valid = 1'b1;
      s_data  = 16'hDEAD;
      s_last  = 1'b0;
      @(negedge clk);
      chk("wdata_passthru", 32'(mem_wdata), 32'h0000_DEAD);
      chk("drain_no_accept", 32'(s_ready), 32'd0);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
